// File: rtl/led_pattern_seq_if.sv
// led_pattern_seq_if: control inputs and LED/status outputs of the LED pattern sequencer
interface led_pattern_seq_if #(
    parameter int N_LED = 16
);
    logic             en;
    logic             dir;
    logic             rot;
    logic [1:0]       speed;
    logic [N_LED-1:0] led;
    logic [1:0]       state_o;
    logic             tick_o;

    modport master (output en, dir, rot, speed, input led, state_o, tick_o);
    modport slave  (input en, dir, rot, speed, output led, state_o, tick_o);
endinterface

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: LED bank sequencer cycling ON -> FLASH -> SHIFT -> EXPAND -> FLASH, paced by a prescaler tick
module led_pattern_seq #(
    parameter int N_LED         = 16,
    parameter int DIV_W         = 25,
    parameter int FLASH_TOGGLES = 12
) (
    input logic              clk,
    input logic              rst_n,
    led_pattern_seq_if.slave bus
);
    localparam int FW = $clog2(FLASH_TOGGLES + 1);
    localparam int SW = $clog2(N_LED);
    localparam logic [1:0] S_ON     = 2'd0;
    localparam logic [1:0] S_FLASH  = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_EXPAND = 2'd3;
    localparam logic [N_LED-1:0] ALL_ONES = '1;
    localparam logic [N_LED-1:0] ALT      = {(N_LED/2){2'b10}};
    localparam logic [N_LED-1:0] CENTER   = {{(N_LED/2-1){1'b0}}, 2'b11, {(N_LED/2-1){1'b0}}};
    localparam logic [FW-1:0] FT       = FW'(FLASH_TOGGLES);
    localparam logic [SW-1:0] STEP_MAX = SW'(N_LED - 1);

    logic [DIV_W-1:0] cnt_q, mask;
    logic             tick_q, adv;
    logic [N_LED-1:0] led_q, led_d, shl, shr, rol, ror;
    logic [1:0]       state_q, state_d;
    logic [FW-1:0]    flash_q, flash_d;
    logic [SW-1:0]    step_q, step_d;

    assign mask = {DIV_W{1'b1}} >> bus.speed;
    assign adv  = tick_q & bus.en;
    assign shl  = {led_q[N_LED-2:0], 1'b0};
    assign shr  = {1'b0, led_q[N_LED-1:1]};
    assign rol  = {led_q[N_LED-2:0], led_q[N_LED-1]};
    assign ror  = {led_q[0], led_q[N_LED-1:1]};

    assign bus.led     = led_q;
    assign bus.state_o = state_q;
    assign bus.tick_o  = tick_q;

    // free-running prescaler; tick fires when the speed-selected low bits are all ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_q + DIV_W'(1);
            tick_q <= &(cnt_q | ~mask);
        end
    end

    // pattern next-state, evaluated only when a tick is accepted
    always_comb begin
        led_d   = led_q;
        state_d = state_q;
        flash_d = flash_q;
        step_d  = step_q;
        if (adv) begin
            case (state_q)
                S_ON: begin
                    led_d   = '0;
                    flash_d = '0;
                    state_d = S_FLASH;
                end
                S_FLASH: begin
                    if (flash_q < FT) begin
                        led_d   = ~led_q;
                        flash_d = flash_q + FW'(1);
                    end else begin
                        led_d   = ALT;
                        step_d  = '0;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    step_d = (step_q == STEP_MAX) ? step_q : step_q + SW'(1);
                    if (bus.rot ? (step_q == STEP_MAX) : (led_q == '0)) begin
                        led_d   = CENTER;
                        state_d = S_EXPAND;
                    end else begin
                        led_d = bus.rot ? (bus.dir ? rol : ror) : (bus.dir ? shl : shr);
                    end
                end
                default: begin
                    if (led_q == ALL_ONES) begin
                        led_d   = '0;
                        flash_d = '0;
                        state_d = S_FLASH;
                    end else if (!bus.dir) begin
                        led_d = led_q | shl | shr;
                    end else if (led_q != CENTER) begin
                        led_d = led_q & shl & shr;
                    end
                end
            endcase
        end
    end

    // pattern registers; reset lights the whole bank in the ON state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q   <= ALL_ONES;
            state_q <= S_ON;
            flash_q <= '0;
            step_q  <= '0;
        end else begin
            led_q   <= led_d;
            state_q <= state_d;
            flash_q <= flash_d;
            step_q  <= step_d;
        end
    end
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: random-stimulus check of led_pattern_seq against a behavioural model
module tb_led_pattern_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    int   m_cnt, m_state, m_led, m_flash, m_step, m_w;
    bit   m_tick;
    bit   did_rst;

    led_pattern_seq_if #(.N_LED(16)) bus ();

    led_pattern_seq #(.N_LED(16), .DIV_W(4), .FLASH_TOGGLES(12)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int band(input int w);
        return ((1 << w) - 1) << (8 - w / 2);
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_tick  = 0;
        m_state = 0;
        m_led   = 16'hFFFF;
        m_flash = 0;
        m_step  = 0;
        m_w     = 2;
    endtask

    task automatic model_edge();
        int p;
        bit nt, adv, done;
        p   = 16 >> bus.speed;
        nt  = (m_cnt % p) == p - 1;
        adv = m_tick && bus.en;
        m_cnt = (m_cnt + 1) % 16;
        if (adv) begin
            case (m_state)
                0: begin
                    m_led = 0; m_flash = 0; m_state = 1;
                end
                1: begin
                    if (m_flash < 12) begin
                        m_led = m_led ^ 16'hFFFF;
                        m_flash++;
                    end else begin
                        m_led = 16'hAAAA; m_step = 0; m_state = 2;
                    end
                end
                2: begin
                    done = bus.rot ? (m_step == 15) : (m_led == 0);
                    if (done) begin
                        m_w = 2; m_led = band(2); m_state = 3;
                    end else if (bus.rot) begin
                        m_led = bus.dir ? ((m_led * 2) % 65536 + m_led / 32768)
                                        : ((m_led % 2) * 32768 + m_led / 2);
                    end else begin
                        m_led = bus.dir ? (m_led * 2) % 65536 : m_led / 2;
                    end
                    if (m_step < 15) m_step++;
                end
                default: begin
                    if (m_w == 16) begin
                        m_led = 0; m_flash = 0; m_state = 1;
                    end else begin
                        if (!bus.dir) m_w += 2;
                        else if (m_w > 2) m_w -= 2;
                        m_led = band(m_w);
                    end
                end
            endcase
        end
        m_tick = nt;
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, "_led"},   int'(bus.led),     m_led);
        chk({pfx, "_state"}, int'(bus.state_o), m_state);
        chk({pfx, "_tick"},  int'(bus.tick_o),  int'(m_tick));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b1; bus.dir = 1'b0; bus.rot = 1'b0; bus.speed = 2'd0;
        did_rst = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        for (int c = 0; c < 8000; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all("run");
            if (c >= 1200) begin
                bus.en = $urandom_range(0, 9) != 0;
                if ($urandom_range(0, 29) == 0) bus.dir = ~bus.dir;
                if ($urandom_range(0, 39) == 0) bus.rot = ~bus.rot;
                if ($urandom_range(0, 299) == 0) bus.speed = 2'($urandom_range(0, 3));
            end
            if ((c >= 3000 && !did_rst && m_state == 3 && m_w > 2) || c == 6500) begin
                did_rst = 1;
                #2 rst_n = 1'b0;
                model_reset();
                #1 check_all("async_rst");
                @(negedge clk);
                check_all("held_rst");
                rst_n = 1'b1;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
